// File: rtl/ref_mem_pkg.sv
// Shared constants, FSM state type and the row/segment -> bank/address mapping
// used by the reference-window memory sequencer.
package ref_mem_pkg;

    localparam int PIXEL     = 8;
    localparam int BANKS     = 32;
    localparam int RD_GROUPS = 4;
    localparam int ADDR_W    = 7;
    localparam int SEG_BITS  = PIXEL * BANKS;
    localparam int BANK_W    = $clog2(BANKS);
    localparam int CNT_W     = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SCAN,
        DRAIN,
        DONE
    } state_e;

    typedef struct packed {
        logic [BANK_W-1:0] bank;
        logic [ADDR_W-1:0] addr;
    } wr_slot_t;

    // Row r lands in bank r mod 32; each 32-row band owns WIN_SEGS consecutive addresses.
    function automatic wr_slot_t map_row(input logic [15:0] row,
                                         input logic [15:0] seg,
                                         input int unsigned win_segs);
        wr_slot_t slot;
        slot.bank = row[BANK_W-1:0];
        slot.addr = ADDR_W'((32'(row) >> BANK_W) * win_segs + 32'(seg));
        return slot;
    endfunction

endpackage

// File: rtl/ref_rd_credit.sv
// Outstanding 8-row read tracker: gates issue at MAX_OUTSTANDING and flags
// returns that arrive with nothing outstanding.
module ref_rd_credit
    import ref_mem_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic issue,
    input  logic ret,
    output logic can_issue,
    output logic empty,
    output logic err
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        cnt_d = cnt_q;
        err_d = err_q;
        if (clear) begin
            cnt_d = '0;
            err_d = 1'b0;
        end else begin
            if (ret && cnt_q == '0) begin
                err_d = 1'b1;
            end
            if (issue && !ret) begin
                cnt_d = cnt_q + 1'b1;
            end else if (ret && !issue && cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign can_issue = cnt_q < CNT_W'(MAX_OUTSTANDING);
    assign empty     = cnt_q == '0;
    assign err       = err_q;

endmodule

// File: rtl/ref_mem_ctrl.sv
// Ref_mem sequencer: streams a search window into the 32 banks, then issues
// 8-row reads under flow control and credit limits, drains, and pulses done.
module ref_mem_ctrl
    import ref_mem_pkg::*;
#(
    parameter int WIN_ROWS        = 64,
    parameter int WIN_SEGS        = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    input  logic [SEG_BITS-1:0]   ref_in,
    input  logic                  ref_in_valid,
    output logic                  ref_in_ready,
    output logic [SEG_BITS-1:0]   ref_input,
    output logic [BANKS-1:0]      Bank_sel,
    output logic [BANKS*ADDR_W-1:0] write_address_all,
    output logic [ADDR_W-1:0]     rd_address,
    output logic                  rd8R_en,
    output logic [3:0]            rdR_sel,
    input  logic                  Oda8R_va,
    input  logic                  da1R_va,
    input  logic                  me_ready
);

    localparam int A_CNT = (WIN_ROWS / 32) * WIN_SEGS;
    localparam int ROW_W = $clog2(WIN_ROWS);
    localparam int SEG_W = (WIN_SEGS > 1) ? $clog2(WIN_SEGS) : 1;
    localparam int GRP_W = $clog2(RD_GROUPS);

    state_e                  state_q, state_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic [SEG_W-1:0]        seg_q, seg_d;
    logic [ADDR_W-1:0]       rd_a_q, rd_a_d;
    logic [GRP_W-1:0]        rd_g_q, rd_g_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    ready_q, ready_d;
    logic [SEG_BITS-1:0]     ref_input_q, ref_input_d;
    logic [BANKS-1:0]        bank_sel_q, bank_sel_d;
    logic [BANKS*ADDR_W-1:0] waddr_q, waddr_d;
    logic [ADDR_W-1:0]       rd_address_q, rd_address_d;
    logic                    rd8r_en_q, rd8r_en_d;
    logic [3:0]              rdr_sel_q, rdr_sel_d;

    logic     accept;
    logic     issue;
    logic     start_ok;
    logic     last_beat;
    logic     last_seg;
    logic     last_read;
    logic     last_grp;
    logic     can_issue;
    logic     credit_empty;
    wr_slot_t slot;

    // 1-row valid belongs to the PE-side consumer; this block has no use for it.
    logic unused_da1r;
    assign unused_da1r = da1R_va;

    ref_rd_credit #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_credit (
        .clk      (clk),
        .rst      (rst),
        .clear    (start_ok),
        .issue    (issue),
        .ret      (Oda8R_va),
        .can_issue(can_issue),
        .empty    (credit_empty),
        .err      (err)
    );

    always_comb begin
        accept    = ref_in_valid && ready_q;
        issue     = (state_q == SCAN) && me_ready && can_issue;
        start_ok  = start && (state_q == IDLE);
        last_seg  = seg_q == SEG_W'(WIN_SEGS - 1);
        last_beat = last_seg && (row_q == ROW_W'(WIN_ROWS - 1));
        last_grp  = rd_g_q == GRP_W'(RD_GROUPS - 1);
        last_read = last_grp && (rd_a_q == ADDR_W'(A_CNT - 1));
        slot      = map_row(16'(row_q), 16'(seg_q), WIN_SEGS);

        state_d      = state_q;
        row_d        = row_q;
        seg_d        = seg_q;
        rd_a_d       = rd_a_q;
        rd_g_d       = rd_g_q;
        bank_sel_d   = '0;
        waddr_d      = waddr_q;
        ref_input_d  = ref_input_q;
        rd8r_en_d    = 1'b0;
        rd_address_d = rd_address_q;
        rdr_sel_d    = rdr_sel_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    row_d   = '0;
                    seg_d   = '0;
                    rd_a_d  = '0;
                    rd_g_d  = '0;
                end
            end
            LOAD: begin
                if (accept) begin
                    bank_sel_d  = {{(BANKS-1){1'b0}}, 1'b1} << slot.bank;
                    waddr_d     = {BANKS{slot.addr}};
                    ref_input_d = ref_in;
                    if (last_beat) begin
                        state_d = SCAN;
                    end else if (last_seg) begin
                        seg_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        seg_d = seg_q + 1'b1;
                    end
                end
            end
            SCAN: begin
                if (issue) begin
                    rd8r_en_d    = 1'b1;
                    rd_address_d = rd_a_q;
                    rdr_sel_d    = 4'(rd_g_q);
                    if (last_read) begin
                        state_d = DRAIN;
                    end else if (last_grp) begin
                        rd_g_d = '0;
                        rd_a_d = rd_a_q + 1'b1;
                    end else begin
                        rd_g_d = rd_g_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (credit_empty) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Status outputs are registered from the next state so they line up with it.
        busy_d  = state_d != IDLE;
        done_d  = state_d == DONE;
        ready_d = state_d == LOAD;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            row_q        <= '0;
            seg_q        <= '0;
            rd_a_q       <= '0;
            rd_g_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ready_q      <= 1'b0;
            ref_input_q  <= '0;
            bank_sel_q   <= '0;
            waddr_q      <= '0;
            rd_address_q <= '0;
            rd8r_en_q    <= 1'b0;
            rdr_sel_q    <= '0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            seg_q        <= seg_d;
            rd_a_q       <= rd_a_d;
            rd_g_q       <= rd_g_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            ready_q      <= ready_d;
            ref_input_q  <= ref_input_d;
            bank_sel_q   <= bank_sel_d;
            waddr_q      <= waddr_d;
            rd_address_q <= rd_address_d;
            rd8r_en_q    <= rd8r_en_d;
            rdr_sel_q    <= rdr_sel_d;
        end
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign ref_in_ready      = ready_q;
    assign ref_input         = ref_input_q;
    assign Bank_sel          = bank_sel_q;
    assign write_address_all = waddr_q;
    assign rd_address        = rd_address_q;
    assign rd8R_en           = rd8r_en_q;
    assign rdR_sel           = rdr_sel_q;

endmodule

// File: tb/tb_ref_mem_ctrl.sv
// Self-checking bench for ref_mem_ctrl: directed window sequence with random
// data, valid gaps, flow control and return latency against a beat/read-index model.
module tb_ref_mem_ctrl;

    localparam int WIN_ROWS    = 64;
    localparam int WIN_SEGS    = 2;
    localparam int MAX_OUT     = 4;
    localparam int TOTAL_BEATS = WIN_ROWS * WIN_SEGS;
    localparam int N_READS     = 4 * (WIN_ROWS / 32) * WIN_SEGS;

    logic         clk;
    logic         rst;
    logic         start;
    logic         busy;
    logic         done;
    logic         err;
    logic [255:0] ref_in;
    logic         ref_in_valid;
    logic         ref_in_ready;
    logic [255:0] ref_input;
    logic [31:0]  Bank_sel;
    logic [223:0] write_address_all;
    logic [6:0]   rd_address;
    logic         rd8R_en;
    logic [3:0]   rdR_sel;
    logic         Oda8R_va;
    logic         da1R_va;
    logic         me_ready;

    ref_mem_ctrl #(
        .WIN_ROWS       (WIN_ROWS),
        .WIN_SEGS       (WIN_SEGS),
        .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .busy             (busy),
        .done             (done),
        .err              (err),
        .ref_in           (ref_in),
        .ref_in_valid     (ref_in_valid),
        .ref_in_ready     (ref_in_ready),
        .ref_input        (ref_input),
        .Bank_sel         (Bank_sel),
        .write_address_all(write_address_all),
        .rd_address       (rd_address),
        .rd8R_en          (rd8R_en),
        .rdR_sel          (rdR_sel),
        .Oda8R_va         (Oda8R_va),
        .da1R_va          (da1R_va),
        .me_ready         (me_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int gcyc  = 0;
    int issued;
    int returned;
    int done_cnt;
    int lat_min;
    int lat_max;
    int last_ret_t;
    bit auto_ret;
    int ret_q[$];

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        gcyc++;
    endtask

    task automatic check_reset(input string tag);
        check_bit({tag, ":busy"}, busy, 1'b0);
        check_bit({tag, ":done"}, done, 1'b0);
        check_bit({tag, ":err"}, err, 1'b0);
        check_bit({tag, ":ready"}, ref_in_ready, 1'b0);
        check_bit({tag, ":rd8R_en"}, rd8R_en, 1'b0);
        check({tag, ":bank_sel"}, 256'(Bank_sel), '0);
        check({tag, ":ref_input"}, ref_input, '0);
        check({tag, ":waddr"}, 256'(write_address_all), '0);
        check({tag, ":rd_address"}, 256'(rd_address), '0);
        check({tag, ":rdR_sel"}, 256'(rdR_sel), '0);
    endtask

    // Streams n_beats raster-order beats after a start pulse; mode 0 = continuous
    // valid, 1 = valid every 3rd cycle, 2 = random valid. inject_at pulses start mid-load.
    task automatic load_window(input int mode, input int n_beats, input int inject_at);
        int k, cyc, nz, row, seg, addr;
        logic v;
        logic [255:0] d;
        logic [31:0]  eb;
        logic [223:0] ew;
        k = 0;
        cyc = 0;
        nz = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        check_bit("start_clears_err", err, 1'b0);
        check_bit("load_ready", ref_in_ready, 1'b1);
        check_bit("load_busy", busy, 1'b1);
        while (k < n_beats && cyc < 4 * TOTAL_BEATS) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 3 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom();
            ref_in       = d;
            ref_in_valid = v;
            start        = (cyc == inject_at);
            step();
            start = 1'b0;
            if (Bank_sel != 32'h0) nz++;
            if (v) begin
                row  = k / WIN_SEGS;
                seg  = k % WIN_SEGS;
                addr = (row / 32) * WIN_SEGS + seg;
                eb   = 32'h1 << (row % 32);
                for (int i = 0; i < 32; i++) ew[i*7 +: 7] = 7'(addr);
                check("wr_bank_sel", 256'(Bank_sel), 256'(eb));
                check("wr_addr", 256'(write_address_all), 256'(ew));
                check("wr_data", ref_input, d);
                if (row == 33 && seg == 1) begin
                    check("row33_seg1_bank", 256'(Bank_sel), 256'(32'h0000_0002));
                    check("row33_seg1_addr", 256'(write_address_all[6:0]), 256'(7'd3));
                end
                k++;
            end else begin
                check("gap_bank_sel", 256'(Bank_sel), '0);
            end
            check_bit("ready_track", ref_in_ready, k < TOTAL_BEATS);
            cyc++;
        end
        ref_in_valid = 1'b0;
        check_int("load_beats", k, n_beats);
        if (n_beats == TOTAL_BEATS) check_int("nonzero_bank_sel_cycles", nz, TOTAL_BEATS);
    endtask

    task automatic begin_scan();
        issued     = 0;
        returned   = 0;
        done_cnt   = 0;
        last_ret_t = gcyc;
        ret_q.delete();
    endtask

    task automatic sched_ret(input int lat);
        int t;
        t = gcyc + lat;
        if (t <= last_ret_t) t = last_ret_t + 1;
        last_ret_t = t;
        ret_q.push_back(t);
    endtask

    // One scan-phase cycle: drive me_ready and (scheduled or manual) Oda8R_va,
    // then check any observed issue against read index order and the credit limit.
    task automatic scan_cycle(input logic mr, input logic manual_ret);
        logic r;
        r = manual_ret;
        if (auto_ret && ret_q.size() > 0 && ret_q[0] <= gcyc) begin
            r = 1'b1;
            void'(ret_q.pop_front());
        end
        me_ready = mr;
        Oda8R_va = r;
        step();
        Oda8R_va = 1'b0;
        if (rd8R_en) begin
            check_bit("credit_limit", (issued - returned) < MAX_OUT, 1'b1);
            check("rd_address_order", 256'(rd_address), 256'(7'(issued / 4)));
            check("rdR_sel_order", 256'(rdR_sel), 256'(4'(issued % 4)));
            issued++;
            if (auto_ret) sched_ret($urandom_range(lat_min, lat_max));
        end
        if (r) returned++;
        if (done) begin
            check_bit("busy_during_done", busy, 1'b1);
            done_cnt++;
        end
    endtask

    task automatic finish_scan(input int mode, input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            scan_cycle((mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0), 1'b0);
            n++;
        end
        check_bit("scan_in_budget", n < budget, 1'b1);
        check_int("read_count", issued, N_READS);
        check_int("all_returned", returned, issued);
        check_int("done_pulses", done_cnt, 1);
        me_ready = 1'b0;
        step();
        check_bit("done_is_pulse", done, 1'b0);
        check_bit("busy_falls_after_done", busy, 1'b0);
        check_bit("no_issue_after_done", rd8R_en, 1'b0);
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        ref_in       = '0;
        ref_in_valid = 1'b0;
        Oda8R_va     = 1'b0;
        da1R_va      = 1'b0;
        me_ready     = 1'b0;
        auto_ret     = 1'b0;
        lat_min      = 2;
        lat_max      = 2;
        repeat (3) @(posedge clk);
        #1;
        check_reset("por");
        rst = 1'b0;
        step();

        // Partial load, then asynchronous reset between clock edges.
        load_window(0, 10, -1);
        #2 rst = 1'b1;
        #1;
        check_reset("mid_load_rst");
        step();
        rst = 1'b0;
        step();
        check_reset("post_rst");

        // Full continuous load, then scan with 2-cycle returns.
        load_window(0, TOTAL_BEATS, -1);
        begin_scan();
        auto_ret = 1'b1;
        lat_min  = 2;
        lat_max  = 2;
        finish_scan(0, 300);

        // Spurious return while idle.
        Oda8R_va = 1'b1;
        step();
        Oda8R_va = 1'b0;
        check_bit("spurious_ret_err", err, 1'b1);
        check_bit("spurious_ret_idle", busy, 1'b0);

        // Gapped load with an ignored start, then credit back-pressure.
        load_window(1, TOTAL_BEATS, 50);
        begin_scan();
        auto_ret = 1'b0;
        repeat (20) scan_cycle(1'b1, 1'b0);
        check_int("withhold_cap", issued, MAX_OUT);
        scan_cycle(1'b1, 1'b1);
        repeat (10) scan_cycle(1'b1, 1'b0);
        check_int("one_return_one_issue", issued, MAX_OUT + 1);
        scan_cycle(1'b0, 1'b1);
        repeat (4) scan_cycle(1'b0, 1'b0);
        check_int("me_ready_low_no_issue", issued, MAX_OUT + 1);
        auto_ret = 1'b1;
        for (int i = issued - returned; i > 0; i--) sched_ret(1);
        finish_scan(0, 400);
        check_bit("err_clear_w3", err, 1'b0);

        // Random valid, random me_ready, random return latency.
        load_window(2, TOTAL_BEATS, -1);
        begin_scan();
        auto_ret = 1'b1;
        lat_min  = 1;
        lat_max  = 4;
        finish_scan(1, 1000);
        check_bit("err_clear_w4", err, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
